// File: rtl/decode_stage.sv
// Registered RISC-V decode stage: decodes one instruction per cycle into an output
// register and stalls read-after-write hazards on a pending-write scoreboard.
module decode_stage #(
  parameter int IMMW  = 22,
  parameter int NREGS = 32,
  parameter int RSW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      pcfunc,
  output logic [IMMW-1:0] pcoffset,
  output logic [RSW-1:0]  readselect1,
  output logic [RSW-1:0]  readselect2,
  output logic            writeenable,
  output logic [RSW-1:0]  writeselect,
  output logic [3:0]      aluoper,
  output logic            selopr2,
  output logic [IMMW-1:0] immediate,
  output logic            illegal,
  input  logic            wb_valid,
  input  logic [RSW-1:0]  wb_select
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [RSW-1:0] field_rd;
  logic [RSW-1:0] field_rs1;
  logic [RSW-1:0] field_rs2;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign field_rd  = instruction[7 +: RSW];
  assign field_rs1 = instruction[15 +: RSW];
  assign field_rs2 = instruction[20 +: RSW];

  logic [IMMW-1:0] imm_i;
  logic [IMMW-1:0] imm_u;
  logic [IMMW-1:0] imm_b;
  logic [IMMW-1:0] imm_j;

  // Width casts sign-extend (or truncate) the RISC-V immediate formats to IMMW.
  assign imm_i = IMMW'($signed(instruction[31:20]));
  assign imm_u = IMMW'({instruction[31:12], 12'b0});
  assign imm_b = IMMW'($signed({instruction[31], instruction[7], instruction[30:25],
                                instruction[11:8], 1'b0}));
  assign imm_j = IMMW'($signed({instruction[31], instruction[19:12], instruction[20],
                                instruction[30:21], 1'b0}));

  logic [1:0]      d_pcfunc;
  logic [IMMW-1:0] d_pcoffset;
  logic [RSW-1:0]  d_rs1;
  logic [RSW-1:0]  d_rs2;
  logic            d_we;
  logic [RSW-1:0]  d_rd;
  logic [3:0]      d_aluoper;
  logic            d_selopr2;
  logic [IMMW-1:0] d_immediate;
  logic            d_illegal;
  logic            rs1_used;
  logic            rs2_used;
  logic            writes_rd;

  always_comb begin
    d_pcfunc    = 2'b00;
    d_pcoffset  = '0;
    d_aluoper   = 4'b0000;
    d_selopr2   = 1'b0;
    d_immediate = '0;
    d_illegal   = 1'b0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    writes_rd   = 1'b0;
    case (opcode)
      OP_R: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
        d_aluoper = {instruction[30], funct3};
      end
      OP_IALU: begin
        rs1_used    = 1'b1;
        writes_rd   = 1'b1;
        d_selopr2   = 1'b1;
        d_immediate = imm_i;
        // Only the shift-right encoding carries an operation bit in instr[30].
        d_aluoper   = (funct3 == 3'b101) ? {instruction[30], funct3} : {1'b0, funct3};
      end
      OP_LUI: begin
        writes_rd   = 1'b1;
        d_selopr2   = 1'b1;
        d_immediate = imm_u;
        d_aluoper   = 4'b1111;
      end
      OP_JAL: begin
        writes_rd  = 1'b1;
        d_pcfunc   = 2'b10;
        d_pcoffset = imm_j;
      end
      OP_JALR: begin
        rs1_used    = 1'b1;
        writes_rd   = 1'b1;
        d_pcfunc    = 2'b11;
        d_selopr2   = 1'b1;
        d_immediate = imm_i;
      end
      OP_BRANCH: begin
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
        d_pcfunc   = 2'b01;
        d_pcoffset = imm_b;
        d_aluoper  = {1'b0, funct3};
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign d_rs1 = rs1_used  ? field_rs1 : '0;
  assign d_rs2 = rs2_used  ? field_rs2 : '0;
  assign d_rd  = writes_rd ? field_rd  : '0;
  assign d_we  = writes_rd && (field_rd != '0);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_nxt;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             hazard;
  logic             capture;
  logic             handoff;

  // A source is busy while its write is still in flight: either already handed
  // to execute (pending bit) or sitting in our own output register.
  assign rs1_busy = (d_rs1 != '0) &&
                    (pending_q[d_rs1] || (out_valid && writeenable && (d_rs1 == writeselect)));
  assign rs2_busy = (d_rs2 != '0) &&
                    (pending_q[d_rs2] || (out_valid && writeenable && (d_rs2 == writeselect)));
  assign hazard   = rs1_busy || rs2_busy;

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // in_ready never looks at in_valid; out_valid never drops without a handoff,
  // flush or reset, and the bundle is frozen while out_valid && !out_ready.
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign capture  = in_valid && in_ready;
  assign handoff  = out_valid && out_ready && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      pcfunc      <= 2'b00;
      pcoffset    <= '0;
      readselect1 <= '0;
      readselect2 <= '0;
      writeenable <= 1'b0;
      writeselect <= '0;
      aluoper     <= 4'b0000;
      selopr2     <= 1'b0;
      immediate   <= '0;
      illegal     <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      pcfunc      <= d_pcfunc;
      pcoffset    <= d_pcoffset;
      readselect1 <= d_rs1;
      readselect2 <= d_rs2;
      writeenable <= d_we;
      writeselect <= d_rd;
      aluoper     <= d_aluoper;
      selopr2     <= d_selopr2;
      immediate   <= d_immediate;
      illegal     <= d_illegal;
    end else if (flush || handoff) begin
      out_valid <= 1'b0;
    end
  end

  // Clear first so that a same-cycle set of the same register wins.
  always_comb begin
    pending_nxt = pending_q;
    if (wb_valid && (wb_select != '0)) pending_nxt[wb_select] = 1'b0;
    if (handoff && writeenable) pending_nxt[writeselect] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_nxt;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised, registered RISC-V decode stage: the successor to the combinational instruction decoder. It accepts one 32-bit instruction per cycle over a valid/ready handshake and produces the same control bundle as the decoder (pcfunc, pcoffset, read/write selects, aluoper, selopr2, immediate) in an output register. A pending-write scoreboard stalls read-after-write hazards until the register file reports writeback. It sits between fetch and execute.

Parameters:
IMMW, 22, width of the sign-extended immediate and pcoffset outputs (legal range 13..32).
NREGS, 32, number of architectural registers tracked by the scoreboard (power of 2, at most 32).
RSW, 5, register-select width; must equal log2(NREGS).

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
instruction  input  32  raw instruction word
flush  input  1  discard the instruction held in the output register
out_valid  output  1  output bundle valid
out_ready  input  1  execute accepts the bundle
pcfunc  output  2  00 PC+4, 01 branch, 10 jal, 11 jalr
pcoffset  output  IMMW  sign-extended branch/jump offset
readselect1  output  RSW  rs1
readselect2  output  RSW  rs2
writeenable  output  1  instruction writes rd
writeselect  output  RSW  rd
aluoper  output  4  ALU operation code
selopr2  output  1  0 = rs2 operand, 1 = immediate operand
immediate  output  IMMW  sign-extended immediate
illegal  output  1  unsupported opcode
wb_valid  input  1  register file completes a write
wb_select  input  RSW  register written back

Behaviour:
- Reset (async, active-high): out_valid=0; all bundle outputs=0; every scoreboard pending bit=0. Reset mid-stall or mid-handoff drops the held instruction.
- Decode:
  - R-type 0110011: aluoper={instr[30],funct3}, selopr2=0, writeenable=1.
  - I-ALU 0010011: selopr2=1, immediate=sext(instr[31:20]); aluoper={instr[30],funct3} when funct3=101, otherwise {0,funct3}.
  - LUI 0110111: immediate={instr[31:12],12'b0}, truncated to IMMW; aluoper=1111, selopr2=1.
  - JAL 1101111: pcfunc=10, writeenable=1, pcoffset=sext(J-imm).
  - JALR 1100111: pcfunc=11, selopr2=1, immediate=sext(I-imm).
  - BRANCH 1100011: pcfunc=01, writeenable=0, pcoffset=sext(B-imm), aluoper={0,funct3}.
  - Any other opcode: illegal=1, writeenable=0, pcfunc=00.
  - Unused fields are 0. writeenable is forced to 0 whenever rd=0.
- Hazard:
  - rsX_used is 1 when the format reads that register.
  - hazard=1 when a used, nonzero rs1 or rs2 has its pending bit set, or equals writeselect of the held bundle while out_valid and writeenable are 1.
  - No bypass: a writeback in cycle N clears the hazard from cycle N+1.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard & !flush. This is combinational; it must not depend on in_valid.
  - Capture on in_valid & in_ready: the bundle registers next edge, out_valid=1. Latency is 1 cycle.
  - When out_valid & out_ready and no new capture: out_valid=0 next edge.
  - The bundle holds stable while out_valid & !out_ready.
- Scoreboard:
  - Set pending[writeselect] on the handoff edge (out_valid & out_ready & writeenable).
  - Clear pending[wb_select] on wb_valid; wb_select=0 is ignored.
  - Simultaneous set and clear of the same register: set wins.
- Flush: out_valid=0 next edge; no handoff occurs, so the scoreboard is not set. in_ready=0 during the flush cycle. Pending bits from earlier handoffs stay set.
- Back-to-back: sustains 1 instruction/cycle with out_ready=1 and no hazards.

Test Plan:
1. Reset, then 0x002081B3 with out_ready=1 -> next cycle out_valid=1, readselect1=1, readselect2=2, writeselect=3, writeenable=1, aluoper=0000, selopr2=0, pcfunc=00.
2. 0x3E808113 -> immediate=1000 (0x3E8), selopr2=1, rs1=1, writeselect=2, aluoper=0000; then 0x40208133 -> aluoper=1000, selopr2=0.
3. Hazard: 0x002081B3 handed off, then 0x00118213 presented -> in_ready=0. Hold for 3 cycles, then pulse wb_valid with wb_select=3 -> in_ready=1 the following cycle and writeselect=4.
4. Backpressure: out_ready=0 with two instructions offered -> first bundle held unchanged and in_ready=0. Raise out_ready -> both emerge in order with no loss or duplicate.
5. 0x008000EF -> pcfunc=10, pcoffset=8, writeselect=1, writeenable=1. 0xFFFFFFFF -> illegal=1, writeenable=0. A rd=0 R-type -> writeenable=0 and no pending bit set.
6. Flush while out_valid=1 and out_ready=0 -> out_valid=0 next cycle and pending[rd] stays clear. Assert reset during a stall -> all outputs and pending bits 0 immediately.
